esc_cmd_ramp: RTL and testbench
===============================

// Module: esc_cmd_ramp
// PURPOSE
//  Upstream command stage for the esc PWM generator; runs on the same 1 MHz timer clock.
//  Accepts target throttle values over a valid/ready handshake and slew-limits them.
//  Updates its 10-bit cmd output once per 2500-cycle (400 Hz) frame, so one PWM pulse
//  always sees a stable cmd.
//  Provides arm gating and a link-loss failsafe that ramps the motor to zero.
// PARAMETERS
//  CMD_W          10    width of tgt/cmd; must match the esc cmd input
//  FRAME_US       2500  frame length in tmr_1Mhz cycles (400 Hz)
//  MAX_STEP       16    max |change| of cmd per frame, in LSBs
//  TIMEOUT_FRAMES 40    frames without an accepted target before failsafe (100 ms)
// PORTS
//  tmr_1Mhz   in   1      1 MHz clock
//  rst_n      in   1      reset; asynchronous, active-low
//  arm        in   1      1 = motor enabled; 0 = cmd forced to 0
//  tgt_valid  in   1      tgt holds a new target
//  tgt_ready  out  1      block can take tgt this cycle
//  tgt        in   CMD_W  requested throttle, 0..1023
//  cmd        out  CMD_W  slew-limited throttle to esc
//  frame      out  1      one-cycle pulse on the cycle cmd updates
//  failsafe   out  1      1 = no target received within timeout
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - fctr=0, cmd=0, frame=0, pend empty, tgt_ready=1, target_q=0.
//   - wdog=TIMEOUT_FRAMES, failsafe=1.
//  Frame counter:
//   - fctr counts 0..FRAME_US-1, then wraps to 0.
//   - tick = (fctr==FRAME_US-1); frame is tick registered, so it is high on the cycle cmd changes.
//  Handshake:
//   - accept = tgt_valid & tgt_ready.
//   - tgt_ready = !pend_full | tick (combinational).
//   - tgt must be held stable while valid & !ready.
//  Pending slot (one entry):
//   - accept without tick: pend<=tgt, pend_full<=1.
//   - tick with pend_full: target_q<=pend.
//   - tick with accept in the same cycle: target_q<=old pend (if full), pend<=tgt, pend_full stays 1.
//   - So a target accepted mid-frame takes effect at the next tick.
//  Watchdog:
//   - accept sets wdog to 0 (this includes accept coincident with tick).
//   - otherwise, on tick, wdog increments, saturating at TIMEOUT_FRAMES.
//   - failsafe = (wdog==TIMEOUT_FRAMES), registered.
//   - failsafe clears the cycle after the next accept.
//  Effective target: eff = (failsafe | !arm) ? 0 : target_q.
//  Slew, applied on the tick cycle only; result visible in cmd the next cycle:
//   - diff computed in CMD_W+1 bits, signed; no wrap.
//   - eff > cmd: cmd += min(eff-cmd, MAX_STEP).
//   - eff < cmd: cmd -= min(cmd-eff, MAX_STEP).
//   - equal: hold.
//   - cmd never exceeds 2^CMD_W-1 and never goes below 0.
//  Disarm:
//   - arm low forces cmd to 0 on the next clock edge, regardless of tick.
//   - While arm is low, cmd stays 0.
//   - After re-arm, cmd ramps from 0 (no jump).
//  Handshake and watchdog keep running while disarmed.
//  Reset mid-frame: all state returns to reset values immediately; fctr restarts at 0.
// TESTING
//  T1 reset:
//   - assert rst_n=0 mid-frame -> cmd=0, frame=0, failsafe=1, tgt_ready=1 with no clock edge.
//  T2 ramp up:
//   - arm=1, accept tgt=1000 -> cmd steps 16,32,...,992 on successive ticks.
//   - cmd=1000 at the 63rd tick; then holds.
//  T3 backpressure:
//   - accept 500, then hold tgt_valid with 700 in the same frame -> tgt_ready=0 until tick.
//   - At tick: 700 accepted, 500 becomes the target; 700 becomes the target one tick later.
//  T4 failsafe:
//   - with cmd=1000, stop sending -> failsafe=1 after 40 ticks.
//   - cmd then decrements 16 per tick to 0.
//   - a new accept clears failsafe.
//  T5 disarm:
//   - arm=0 during the T2 ramp at cmd=480 -> cmd=0 next cycle, stays 0.
//   - arm=1 -> cmd restarts at 16 on the next tick.
//  T6 coincident:
//   - accept on the tick cycle with failsafe set -> wdog=0, failsafe clears.
//   - that tick's slew still uses eff=0.

Source files
------------

// File: rtl/esc_cmd_ramp.sv
// rtl/esc_cmd_ramp.sv - slew-limited, frame-synchronous throttle command stage for the esc PWM
//
// Purpose: accepts throttle targets over a valid/ready handshake and moves cmd toward the
// target by at most MAX_STEP per FRAME_US-cycle frame. cmd is updated only at frame
// boundaries, so a PWM pulse never sees cmd change mid-pulse. Arm gating forces cmd to 0.
// A link-loss watchdog ramps the motor down to 0.
//
// Ports:
//   tmr_1Mhz   in   1      1 MHz timer clock
//   rst_n      in   1      asynchronous active-low reset
//   arm        in   1      1 = motor enabled, 0 = cmd forced to 0
//   tgt_valid  in   1      tgt holds a new target
//   tgt_ready  out  1      block can take tgt this cycle
//   tgt        in   CMD_W  requested throttle
//   cmd        out  CMD_W  slew-limited throttle to the esc
//   frame      out  1      one-cycle pulse on the cycle cmd updates
//   failsafe   out  1      1 = no target accepted within TIMEOUT_FRAMES frames
module esc_cmd_ramp #(
  parameter int CMD_W          = 10,
  parameter int FRAME_US       = 2500,
  parameter int MAX_STEP       = 16,
  parameter int TIMEOUT_FRAMES = 40
) (
  input  logic             tmr_1Mhz,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [CMD_W-1:0] tgt,
  output logic [CMD_W-1:0] cmd,
  output logic             frame,
  output logic             failsafe
);

  localparam int FC_W = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int WD_W = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [FC_W-1:0]       FC_LAST = FC_W'(FRAME_US - 1);
  localparam logic [WD_W-1:0]       WD_MAX  = WD_W'(TIMEOUT_FRAMES);
  localparam logic [CMD_W-1:0]      STEP_U  = CMD_W'(MAX_STEP);
  localparam logic signed [CMD_W:0] STEP_S  = (CMD_W + 1)'(MAX_STEP);

  logic [FC_W-1:0]       fctr;
  logic                  tick;
  logic                  accept;
  logic [CMD_W-1:0]      pend;
  logic                  pend_full;
  logic [CMD_W-1:0]      target_q;
  logic [WD_W-1:0]       wdog;
  logic [WD_W-1:0]       wdog_nxt;
  logic [CMD_W-1:0]      eff;
  logic signed [CMD_W:0] diff;
  logic [CMD_W-1:0]      slew;

  assign tick = (fctr == FC_LAST);

  // The pending slot drains into target_q on the tick, so it can refill in the same cycle.
  assign tgt_ready = !pend_full || tick;
  assign accept    = tgt_valid && tgt_ready;

  always_ff @(posedge tmr_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      fctr <= '0;
    end else if (tick) begin
      fctr <= '0;
    end else begin
      fctr <= fctr + 1'b1;
    end
  end

  always_ff @(posedge tmr_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
      target_q  <= '0;
    end else begin
      if (tick && pend_full) begin
        target_q <= pend;
      end
      if (accept) begin
        pend      <= tgt;
        pend_full <= 1'b1;
      end else if (tick) begin
        pend_full <= 1'b0;
      end
    end
  end

  always_comb begin
    wdog_nxt = wdog;
    if (accept) begin
      wdog_nxt = '0;
    end else if (tick && (wdog != WD_MAX)) begin
      wdog_nxt = wdog + 1'b1;
    end
  end

  // failsafe is registered from the next watchdog value so it drops the cycle after an accept.
  always_ff @(posedge tmr_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      wdog     <= WD_MAX;
      failsafe <= 1'b1;
    end else begin
      wdog     <= wdog_nxt;
      failsafe <= (wdog_nxt == WD_MAX);
    end
  end

  assign eff = (failsafe || !arm) ? '0 : target_q;

  // Sign-extended difference cannot wrap; when |diff| <= MAX_STEP the result is eff itself.
  assign diff = $signed({1'b0, eff}) - $signed({1'b0, cmd});

  always_comb begin
    slew = eff;
    if (diff > STEP_S) begin
      slew = cmd + STEP_U;
    end else if (diff < -STEP_S) begin
      slew = cmd - STEP_U;
    end
  end

  always_ff @(posedge tmr_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      cmd   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= tick;
      if (!arm) begin
        cmd <= '0;
      end else if (tick) begin
        cmd <= slew;
      end
    end
  end

endmodule

// File: tb/tb_esc_cmd_ramp.sv
// tb/tb_esc_cmd_ramp.sv - self-checking bench for esc_cmd_ramp against a queue-based reference model
module tb_esc_cmd_ramp;

  localparam int W = 10;
  localparam int F = 20;
  localparam int S = 16;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         arm = 1'b0;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt = '0;
  logic         tgt_ready;
  logic [W-1:0] cmd;
  logic         frame;
  logic         failsafe;

  always #5 clk = ~clk;

  esc_cmd_ramp #(
    .CMD_W(W),
    .FRAME_US(F),
    .MAX_STEP(S),
    .TIMEOUT_FRAMES(T)
  ) dut (
    .tmr_1Mhz(clk),
    .rst_n(rst_n),
    .arm(arm),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt(tgt),
    .cmd(cmd),
    .frame(frame),
    .failsafe(failsafe)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycle position in frame, target list, frames since last accept.
  int m_pos;
  int m_cmd;
  int m_tq;
  int m_quiet;
  bit m_fs;
  bit m_frame;
  int m_pend[$];
  bit last_acc;

  function automatic void m_reset();
    m_pos   = 0;
    m_cmd   = 0;
    m_tq    = 0;
    m_quiet = T;
    m_fs    = 1'b1;
    m_frame = 1'b0;
    m_pend.delete();
    last_acc = 1'b0;
  endfunction

  function automatic bit m_tick();
    return m_pos == F - 1;
  endfunction

  function automatic bit m_ready();
    return (m_pend.size() == 0) || m_tick();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      if (n_err <= 20) $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit tick, acc, a;
    int eff, d, t;
    tick = m_tick();
    acc  = tgt_valid && m_ready();
    a    = arm;
    t    = int'(tgt);
    eff  = (m_fs || !a) ? 0 : m_tq;
    @(posedge clk);
    if (tick && m_pend.size() > 0) m_tq = m_pend.pop_front();
    if (acc) m_pend.push_back(t);
    if (!a) begin
      m_cmd = 0;
    end else if (tick) begin
      d = eff - m_cmd;
      if (d > S) d = S;
      if (d < -S) d = -S;
      m_cmd += d;
    end
    if (acc) m_quiet = 0;
    else if (tick && m_quiet < T) m_quiet++;
    m_fs     = (m_quiet == T);
    m_frame  = tick;
    m_pos    = (m_pos + 1) % F;
    last_acc = acc;
    @(negedge clk);
    chk("cmd", cmd, m_cmd);
    chk("frame", frame, m_frame);
    chk("failsafe", failsafe, m_fs);
    chk("tgt_ready", tgt_ready, m_ready());
  endtask

  // Holds tgt stable while an offered target has not been taken.
  task automatic drive(input int prob, input bit fixed, input int val);
    if (tgt_valid && !last_acc) return;
    tgt_valid = ($urandom_range(999) < prob);
    tgt = fixed ? W'(val) : W'($urandom_range(1023));
  endtask

  task automatic run(input int n, input int prob, input bit fixed, input int val, input int arm_flip);
    repeat (n) begin
      drive(prob, fixed, val);
      if (arm_flip > 0 && $urandom_range(arm_flip - 1) == 0) arm = ~arm;
      step();
    end
  endtask

  // Entered just after a falling edge; reset asserts and releases before the next rising edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    tgt_valid = 1'b0;
    #1;
    chk("rst_cmd", cmd, 0);
    chk("rst_frame", frame, 0);
    chk("rst_failsafe", failsafe, 1);
    chk("rst_tgt_ready", tgt_ready, 1);
    m_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    int prev;
    m_reset();
    repeat (7) @(negedge clk);
    do_reset();

    // Ramp to 1000 with regular refreshes so the watchdog stays quiet.
    arm = 1'b1;
    run(80 * F, 300, 1'b1, 1000, 0);
    chk("ramp_top", cmd, 1000);

    // Link loss: wait for the watchdog to trip.
    tgt_valid = 1'b0;
    guard = 0;
    while (!m_fs && guard < 10 * F) begin
      step();
      guard++;
    end
    chk("fs_timeout", failsafe, 1);

    // Accept exactly on the tick while failsafe is set: slew still heads toward 0.
    guard = 0;
    while (m_pos != F - 1 && guard < F) begin
      step();
      guard++;
    end
    prev = m_cmd;
    tgt_valid = 1'b1;
    tgt = W'(1000);
    step();
    tgt_valid = 1'b0;
    chk("coinc_slew", cmd, prev - S);
    chk("coinc_fs_clear", failsafe, 0);

    // Disarm forces 0 on the next edge; re-arm ramps from 0.
    step();
    arm = 1'b0;
    step();
    chk("disarm", cmd, 0);
    run(3, 0, 1'b0, 0, 0);
    chk("disarm_hold", cmd, 0);
    arm = 1'b1;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!m_frame && guard < 2 * F);
    chk("rearm_first", cmd, S);

    // Silence: failsafe decays cmd to zero.
    run(90 * F, 0, 1'b0, 0, 0);
    chk("fs_decay", cmd, 0);
    chk("fs_held", failsafe, 1);

    // Random traffic with arm toggles and mid-frame resets.
    for (int k = 0; k < 5; k++) begin
      arm = 1'b1;
      run(300 * F + $urandom_range(F - 1), 60, 1'b0, 0, 400);
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
